// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue
// Producer end of the fetch-entry valid/ready interface into decode. Buffers
// frontend instructions (word, PC, exception, branch prediction) in a small
// circular buffer and presents the oldest one as a first-word-fall-through
// head entry. An entry pushed in cycle N reaches the head in cycle N+1; there
// is no push-to-pop bypass.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   drop everything buffered and offered this cycle
//   push_*                    frontend side (valid/ready plus payload)
//   fetch_entry_*             decode side (valid/ready plus head payload)
//   count_o                   occupancy, 0..DEPTH
//   ex_blocked_o              push side closed after an exception entry

module fetch_entry_queue #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 64,
    parameter int XLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [31:0]              push_instr_i,
    input  logic [VLEN-1:0]          push_addr_i,
    input  logic                     push_ex_valid_i,
    input  logic [XLEN-1:0]          push_ex_cause_i,
    input  logic [XLEN-1:0]          push_ex_tval_i,
    input  logic                     push_bp_taken_i,
    input  logic [VLEN-1:0]          push_bp_target_i,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [31:0]              fetch_entry_instr_o,
    output logic [VLEN-1:0]          fetch_entry_addr_o,
    output logic                     fetch_entry_ex_valid_o,
    output logic [XLEN-1:0]          fetch_entry_ex_cause_o,
    output logic [XLEN-1:0]          fetch_entry_ex_tval_o,
    output logic                     fetch_entry_bp_taken_o,
    output logic [VLEN-1:0]          fetch_entry_bp_target_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ex_blocked_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [31:0]     r_instr     [DEPTH];
    logic [VLEN-1:0] r_addr      [DEPTH];
    logic            r_ex_valid  [DEPTH];
    logic [XLEN-1:0] r_ex_cause  [DEPTH];
    logic [XLEN-1:0] r_ex_tval   [DEPTH];
    logic            r_bp_taken  [DEPTH];
    logic [VLEN-1:0] r_bp_target [DEPTH];

    logic [PTRW-1:0] r_rd_ptr;
    logic [PTRW-1:0] r_wr_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_ex_blocked;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNTW'(DEPTH));

    // Ready ignores the decode side on purpose: a full queue refuses even
    // when a pop happens in the same cycle, keeping ready free of any path
    // from decode back to the frontend.
    assign push_ready_o = !w_full && !r_ex_blocked && !flush_i;

    assign w_push = push_valid_i && push_ready_o;
    assign w_pop  = !w_empty && fetch_entry_ready_i && !flush_i;

    assign fetch_entry_valid_o = !w_empty;
    assign count_o             = r_count;
    assign ex_blocked_o        = r_ex_blocked;

    // Head payload is zeroed while empty so decode never sees stale slots.
    assign fetch_entry_instr_o     = w_empty ? '0 : r_instr[r_rd_ptr];
    assign fetch_entry_addr_o      = w_empty ? '0 : r_addr[r_rd_ptr];
    assign fetch_entry_ex_valid_o  = w_empty ? 1'b0 : r_ex_valid[r_rd_ptr];
    assign fetch_entry_ex_cause_o  = w_empty ? '0 : r_ex_cause[r_rd_ptr];
    assign fetch_entry_ex_tval_o   = w_empty ? '0 : r_ex_tval[r_rd_ptr];
    assign fetch_entry_bp_taken_o  = w_empty ? 1'b0 : r_bp_taken[r_rd_ptr];
    assign fetch_entry_bp_target_o = w_empty ? '0 : r_bp_target[r_rd_ptr];

    // Payload storage needs no reset; unwritten slots are never exposed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_instr[r_wr_ptr]     <= push_instr_i;
            r_addr[r_wr_ptr]      <= push_addr_i;
            r_ex_valid[r_wr_ptr]  <= push_ex_valid_i;
            r_ex_cause[r_wr_ptr]  <= push_ex_cause_i;
            r_ex_tval[r_wr_ptr]   <= push_ex_tval_i;
            r_bp_taken[r_wr_ptr]  <= push_bp_taken_i;
            r_bp_target[r_wr_ptr] <= push_bp_target_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Flush wins
    // over everything and also reopens the push side after an exception.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_ex_blocked <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_ex_blocked <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNTW'(1);
            end
            if (w_push && push_ex_valid_i) begin
                r_ex_blocked <= 1'b1;
            end
        end
    end

    a_count_bound : assert property (
        @(posedge clk_i) disable iff (!rst_ni) r_count <= CNTW'(DEPTH)
    );

endmodule

// File: tb/tb_fetch_entry_queue.sv
// tb_fetch_entry_queue
// Directed vector table for fill, full-with-pop, drain, exception blocking and
// flush, followed by hand-written streaming/wrap and asynchronous reset
// sequences. Inputs are driven 1 ns after the rising edge; outputs are
// compared on the falling edge, i.e. they reflect the state before the next
// rising edge combined with the inputs of the current cycle.

module tb_fetch_entry_queue;

    localparam int DEPTH = 4;
    localparam int VLEN  = 64;
    localparam int XLEN  = 64;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_i;
    logic            push_valid_i;
    logic            push_ready_o;
    logic [31:0]     push_instr_i;
    logic [VLEN-1:0] push_addr_i;
    logic            push_ex_valid_i;
    logic [XLEN-1:0] push_ex_cause_i;
    logic [XLEN-1:0] push_ex_tval_i;
    logic            push_bp_taken_i;
    logic [VLEN-1:0] push_bp_target_i;
    logic            fetch_entry_valid_o;
    logic            fetch_entry_ready_i;
    logic [31:0]     fetch_entry_instr_o;
    logic [VLEN-1:0] fetch_entry_addr_o;
    logic            fetch_entry_ex_valid_o;
    logic [XLEN-1:0] fetch_entry_ex_cause_o;
    logic [XLEN-1:0] fetch_entry_ex_tval_o;
    logic            fetch_entry_bp_taken_o;
    logic [VLEN-1:0] fetch_entry_bp_target_o;
    logic [2:0]      count_o;
    logic            ex_blocked_o;

    int checkCount;
    int failCount;
    int vecIdx;

    fetch_entry_queue #(.DEPTH(DEPTH), .VLEN(VLEN), .XLEN(XLEN)) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .flush_i                 (flush_i),
        .push_valid_i            (push_valid_i),
        .push_ready_o            (push_ready_o),
        .push_instr_i            (push_instr_i),
        .push_addr_i             (push_addr_i),
        .push_ex_valid_i         (push_ex_valid_i),
        .push_ex_cause_i         (push_ex_cause_i),
        .push_ex_tval_i          (push_ex_tval_i),
        .push_bp_taken_i         (push_bp_taken_i),
        .push_bp_target_i        (push_bp_target_i),
        .fetch_entry_valid_o     (fetch_entry_valid_o),
        .fetch_entry_ready_i     (fetch_entry_ready_i),
        .fetch_entry_instr_o     (fetch_entry_instr_o),
        .fetch_entry_addr_o      (fetch_entry_addr_o),
        .fetch_entry_ex_valid_o  (fetch_entry_ex_valid_o),
        .fetch_entry_ex_cause_o  (fetch_entry_ex_cause_o),
        .fetch_entry_ex_tval_o   (fetch_entry_ex_tval_o),
        .fetch_entry_bp_taken_o  (fetch_entry_bp_taken_o),
        .fetch_entry_bp_target_o (fetch_entry_bp_target_o),
        .count_o                 (count_o),
        .ex_blocked_o            (ex_blocked_o)
    );

    // 10 ns clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic        flush;
        logic        pushValid;
        logic [63:0] pushAddr;
        logic        pushEx;
        logic [63:0] pushCause;
        logic [63:0] pushTval;
        logic        ready;
        int          expCount;
        logic        expValid;
        logic [63:0] expAddr;
        logic        expPushReady;
        logic        expExBlocked;
        logic        expEx;
        logic [63:0] expCause;
        logic [63:0] expTval;
    } vec_t;

    vec_t vecs[$];

    // Other payload fields are derived from the PC so every entry is distinct.
    function automatic logic [31:0] instrOf(logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] targetOf(logic [63:0] addr);
        return addr + 64'h40;
    endfunction

    function automatic vec_t mk(logic fl, logic pv, logic [63:0] pa, logic pe,
                                logic [63:0] pc, logic [63:0] pt, logic rd,
                                int ec, logic [63:0] ea, logic epr, logic eeb,
                                logic eex, logic [63:0] ecs, logic [63:0] etv);
        vec_t v;
        v.flush = fl;  v.pushValid = pv; v.pushAddr = pa; v.pushEx = pe;
        v.pushCause = pc; v.pushTval = pt; v.ready = rd;
        v.expCount = ec; v.expValid = (ec != 0); v.expAddr = ea;
        v.expPushReady = epr; v.expExBlocked = eeb; v.expEx = eex;
        v.expCause = ecs; v.expTval = etv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, vecIdx, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic pv, input logic [63:0] pa,
                                 input logic pe, input logic [63:0] pc,
                                 input logic [63:0] pt, input logic rd);
        flush_i             = fl;
        push_valid_i        = pv;
        push_addr_i         = pa;
        push_instr_i        = instrOf(pa);
        push_ex_valid_i     = pe;
        push_ex_cause_i     = pc;
        push_ex_tval_i      = pt;
        push_bp_taken_i     = pa[2];
        push_bp_target_i    = targetOf(pa);
        fetch_entry_ready_i = rd;
    endtask

    // Compares the full head view against an expected occupancy/head PC.
    task automatic checkHead(input int ec, input logic [63:0] ea, input logic epr,
                             input logic eeb, input logic eex, input logic [63:0] ecs,
                             input logic [63:0] etv);
        logic        ev;
        logic [63:0] expInstr;
        logic [63:0] expTarget;
        logic        expTaken;
        ev        = (ec != 0);
        expInstr  = ev ? {32'h0, instrOf(ea)} : 64'h0;
        expTarget = ev ? targetOf(ea) : 64'h0;
        expTaken  = ev ? ea[2] : 1'b0;
        checkOutput("count", {61'h0, count_o}, 64'(ec));
        checkOutput("valid", {63'h0, fetch_entry_valid_o}, {63'h0, ev});
        checkOutput("push_ready", {63'h0, push_ready_o}, {63'h0, epr});
        checkOutput("ex_blocked", {63'h0, ex_blocked_o}, {63'h0, eeb});
        checkOutput("head_addr", fetch_entry_addr_o, ea);
        checkOutput("head_instr", {32'h0, fetch_entry_instr_o}, expInstr);
        checkOutput("head_bp_target", fetch_entry_bp_target_o, expTarget);
        checkOutput("head_bp_taken", {63'h0, fetch_entry_bp_taken_o}, {63'h0, expTaken});
        checkOutput("head_ex_valid", {63'h0, fetch_entry_ex_valid_o}, {63'h0, eex});
        checkOutput("head_ex_cause", fetch_entry_ex_cause_o, ecs);
        checkOutput("head_ex_tval", fetch_entry_ex_tval_o, etv);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        vecIdx     = 0;
        rst_ni     = 1'b0;
        applyStimulus(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);

        // Fill four entries with decode stalled
        vecs.push_back(mk(0,0,64'h0,   0,0,0,0, 0,64'h0,   1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h1000,0,0,0,0, 0,64'h0,   1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h1004,0,0,0,0, 1,64'h1000,1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h1008,0,0,0,0, 2,64'h1000,1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h100C,0,0,0,0, 3,64'h1000,1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h1010,0,0,0,0, 4,64'h1000,0,0,0,0,0));
        // Full with pop: push refused, then taken the next cycle
        vecs.push_back(mk(0,1,64'h1010,0,0,0,1, 4,64'h1000,0,0,0,0,0));
        vecs.push_back(mk(0,1,64'h1010,0,0,0,0, 3,64'h1004,1,0,0,0,0));
        // Drain in order
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 4,64'h1004,0,0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 3,64'h1008,1,0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 2,64'h100C,1,0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 1,64'h1010,1,0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 0,64'h0,   1,0,0,0,0));
        // Exception entry closes the push side until flush
        vecs.push_back(mk(0,1,64'h3000,1,64'h1,64'h2000,0, 0,64'h0,1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h3004,0,0,0,0, 1,64'h3000,0,1,1,64'h1,64'h2000));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 1,64'h3000,0,1,1,64'h1,64'h2000));
        vecs.push_back(mk(0,1,64'h3008,0,0,0,1, 0,64'h0,   0,1,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,0, 0,64'h0,   0,1,0,0,0));
        vecs.push_back(mk(1,1,64'h300C,0,0,0,1, 0,64'h0,   0,1,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,0, 0,64'h0,   1,0,0,0,0));
        // Flush with three entries plus a concurrent push and pop
        vecs.push_back(mk(0,1,64'h4000,0,0,0,0, 0,64'h0,   1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h4004,0,0,0,0, 1,64'h4000,1,0,0,0,0));
        vecs.push_back(mk(0,1,64'h4008,0,0,0,0, 2,64'h4000,1,0,0,0,0));
        vecs.push_back(mk(1,1,64'h400C,0,0,0,1, 3,64'h4000,0,0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,   0,0,0,1, 0,64'h0,   1,0,0,0,0));

        // Reset state
        #12;
        checkHead(0, 64'h0, 1, 0, 0, 64'h0, 64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        nextCycle();

        foreach (vecs[i]) begin
            vecIdx = i;
            applyStimulus(vecs[i].flush, vecs[i].pushValid, vecs[i].pushAddr,
                          vecs[i].pushEx, vecs[i].pushCause, vecs[i].pushTval,
                          vecs[i].ready);
            @(negedge clk_i);
            checkHead(vecs[i].expCount, vecs[i].expAddr, vecs[i].expPushReady,
                      vecs[i].expExBlocked, vecs[i].expEx, vecs[i].expCause,
                      vecs[i].expTval);
            nextCycle();
        end

        // Streaming: one push and one pop per cycle across several pointer wraps
        for (int i = 0; i < 22; i++) begin
            vecIdx = 100 + i;
            applyStimulus(0, (i < 20), 64'h5000 + 64'(4 * i), 0, 64'h0, 64'h0, 1);
            @(negedge clk_i);
            if (i == 0 || i == 21) begin
                checkHead(0, 64'h0, 1, 0, 0, 64'h0, 64'h0);
            end else begin
                checkHead(1, 64'h5000 + 64'(4 * (i - 1)), 1, 0, 0, 64'h0, 64'h0);
            end
            nextCycle();
        end

        // Asynchronous reset mid-cycle with entries buffered and push blocked
        vecIdx = 200;
        applyStimulus(0, 1, 64'h6000, 0, 64'h0, 64'h0, 0);
        nextCycle();
        applyStimulus(0, 1, 64'h6004, 1, 64'h5, 64'h7, 0);
        nextCycle();
        applyStimulus(0, 0, 64'h0, 0, 64'h0, 64'h0, 0);
        @(negedge clk_i);
        checkHead(2, 64'h6000, 0, 1, 0, 64'h0, 64'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        vecIdx = 201;
        checkHead(0, 64'h0, 1, 0, 0, 64'h0, 64'h0);
        nextCycle();
        rst_ni = 1'b1;
        nextCycle();
        vecIdx = 202;
        checkHead(0, 64'h0, 1, 0, 0, 64'h0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
